// File: rtl/crc_engine.sv
// Bit-serial CRC engine. Each accepted word is shifted MSB first, one bit per clock.
// A frame produces a held result (CRC, check error, truncation flag, word count).
module crc_engine #(
    parameter int               DATA_W    = 8,
    parameter int               CRC_W     = 14,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(14'h0599),
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter int               MAX_WORDS = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mode,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_W-1:0]                  in_data,
    input  logic                               in_last,
    input  logic [CRC_W-1:0]                   crc_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CRC_W-1:0]                   out_crc,
    output logic                               out_err,
    output logic                               out_len_err,
    output logic [$clog2(MAX_WORDS+1)-1:0]     out_words,
    output logic                               busy
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CRC_W-1:0]   crc_q;
    logic [DATA_W-1:0]  shreg_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               mode_q;
    logic               last_q;
    logic               trunc_q;
    logic [CRC_W-1:0]   crc_in_q;

    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [CRC_W-1:0]   out_crc_q;
    logic               out_err_q;
    logic               out_len_err_q;
    logic [CNT_W-1:0]   out_words_q;

    logic               accept;
    logic               fb;
    logic [CRC_W-1:0]   crc_d;
    logic [CNT_W-1:0]   word_cnt_d;
    logic               hit_max;
    logic               shift_done;

    always_comb begin
        accept     = in_valid && in_ready_q;
        fb         = shreg_q[DATA_W-1] ^ crc_q[CRC_W-1];
        crc_d      = (crc_q << 1) ^ (fb ? POLY : '0);
        // The word count restarts at the first word of every frame.
        word_cnt_d = ((state_q == IDLE) ? '0 : word_cnt_q) + CNT_W'(1);
        hit_max    = (word_cnt_d == CNT_W'(MAX_WORDS));
        shift_done = (bit_cnt_q == BIT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            crc_q         <= INIT;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            mode_q        <= 1'b0;
            last_q        <= 1'b0;
            trunc_q       <= 1'b0;
            crc_in_q      <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            out_crc_q     <= '0;
            out_err_q     <= 1'b0;
            out_len_err_q <= 1'b0;
            out_words_q   <= '0;
        end else begin
            case (state_q)
                IDLE, WAIT: begin
                    if (accept) begin
                        if (state_q == IDLE) begin
                            crc_q  <= INIT;
                            mode_q <= mode;
                        end
                        shreg_q    <= in_data;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= word_cnt_d;
                        last_q     <= in_last || hit_max;
                        trunc_q    <= !in_last && hit_max;
                        // Overwritten by every word, so only the last word's value survives.
                        crc_in_q   <= crc_in;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    crc_q     <= crc_d;
                    shreg_q   <= shreg_q << 1;
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    if (shift_done) begin
                        if (last_q) begin
                            state_q       <= DONE;
                            out_valid_q   <= 1'b1;
                            out_crc_q     <= crc_d;
                            out_err_q     <= mode_q && (crc_d != crc_in_q);
                            out_len_err_q <= trunc_q;
                            out_words_q   <= word_cnt_q;
                        end else begin
                            state_q    <= WAIT;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_crc     = out_crc_q;
    assign out_err     = out_err_q;
    assign out_len_err = out_len_err_q;
    assign out_words   = out_words_q;

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine: a default instance and a MAX_WORDS=2 instance
// share one stimulus driver; a reference model queues expected frame results.
module tb_crc_engine;

    localparam logic [13:0] POLY_REF = 14'h0599;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic [13:0] crc_in;
    logic        out_ready;
    logic        sel;

    logic        in_ready_a, out_valid_a, out_err_a, out_len_err_a, busy_a;
    logic [13:0] out_crc_a;
    logic [4:0]  out_words_a;
    logic        in_ready_b, out_valid_b, out_err_b, out_len_err_b, busy_b;
    logic [13:0] out_crc_b;
    logic [1:0]  out_words_b;

    logic        in_ready_m, out_valid_m, out_err_m, out_len_err_m, busy_m;
    logic [13:0] out_crc_m;
    logic [4:0]  out_words_m;

    always #5 clk = ~clk;

    crc_engine #(.DATA_W(8), .CRC_W(14), .POLY(14'h0599), .INIT(14'h0), .MAX_WORDS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .crc_in(crc_in), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_crc(out_crc_a), .out_err(out_err_a),
        .out_len_err(out_len_err_a), .out_words(out_words_a), .busy(busy_a)
    );

    crc_engine #(.DATA_W(8), .CRC_W(14), .POLY(14'h0599), .INIT(14'h0), .MAX_WORDS(2)) u_dut_mw2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid && sel), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .crc_in(crc_in), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_crc(out_crc_b), .out_err(out_err_b),
        .out_len_err(out_len_err_b), .out_words(out_words_b), .busy(busy_b)
    );

    assign in_ready_m    = sel ? in_ready_b    : in_ready_a;
    assign out_valid_m   = sel ? out_valid_b   : out_valid_a;
    assign out_err_m     = sel ? out_err_b     : out_err_a;
    assign out_len_err_m = sel ? out_len_err_b : out_len_err_a;
    assign busy_m        = sel ? busy_b        : busy_a;
    assign out_crc_m     = sel ? out_crc_b     : out_crc_a;
    assign out_words_m   = sel ? {3'b000, out_words_b} : out_words_a;

    typedef struct {
        logic [13:0] crc;
        logic        err;
        logic        len_err;
        int          words;
    } res_t;

    res_t        exp_q[$];
    res_t        mon_r;
    int          n_cmp = 0;
    int          n_mis = 0;

    logic [13:0] m_crc;
    int          m_cnt;
    logic        m_mode;
    logic        m_active;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model, advanced once per accepted word.
    task automatic model_word(input logic [7:0] d, input logic last, input logic md,
                              input logic [13:0] ci, input int maxw);
        logic fbb;
        res_t r;
        if (!m_active) begin
            m_crc    = 14'h0;
            m_mode   = md;
            m_cnt    = 0;
            m_active = 1'b1;
        end
        for (int b = 7; b >= 0; b--) begin
            fbb   = d[b] ^ m_crc[13];
            m_crc = {m_crc[12:0], 1'b0} ^ (fbb ? POLY_REF : 14'h0);
        end
        m_cnt++;
        if (last || m_cnt == maxw) begin
            r.crc     = m_crc;
            r.err     = m_mode && (m_crc != ci);
            r.len_err = !last && (m_cnt == maxw);
            r.words   = m_cnt;
            exp_q.push_back(r);
            m_active  = 1'b0;
        end
    endtask

    // Returns just after the accepting edge.
    task automatic send_word(input logic [7:0] d, input logic last, input logic md,
                             input logic [13:0] ci, input bit use_model);
        int k;
        @(negedge clk);
        in_data  = d;
        in_last  = last;
        mode     = md;
        crc_in   = ci;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready_m && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready_m) begin
            chk_eq("in_ready_timeout", 32'(in_ready_m), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (use_model) model_word(d, last, md, ci, sel ? 2 : 16);
        $display("send: inst=%0d data=0x%02h last=%0d mode=%0d crc_in=0x%04h", sel, d, last, md, ci);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts edges from acceptance until out_valid is seen.
    task automatic wait_valid(output int k);
        k = 0;
        @(negedge clk);
        while (!out_valid_m && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (!out_valid_m) chk_eq("out_valid_timeout", 32'(out_valid_m), 32'd1);
    endtask

    task automatic check_ready_gap(input string tag);
        int lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!in_ready_m) lows++;
        end
        chk_eq(tag, 32'(lows), 32'd8);
    endtask

    task automatic check_reset_values(input string tag);
        chk_eq({tag, "_in_ready"},  32'(in_ready_m),    32'd1);
        chk_eq({tag, "_out_valid"}, 32'(out_valid_m),   32'd0);
        chk_eq({tag, "_busy"},      32'(busy_m),        32'd0);
        chk_eq({tag, "_out_crc"},   32'(out_crc_m),     32'd0);
        chk_eq({tag, "_out_err"},   32'(out_err_m),     32'd0);
        chk_eq({tag, "_len_err"},   32'(out_len_err_m), 32'd0);
        chk_eq({tag, "_words"},     32'(out_words_m),   32'd0);
    endtask

    always @(negedge clk) begin
        if (out_valid_m && out_ready) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_result", 32'(out_valid_m), 32'd0);
            end else begin
                mon_r = exp_q.pop_front();
                chk_eq("sb_crc",     32'(out_crc_m),     32'(mon_r.crc));
                chk_eq("sb_err",     32'(out_err_m),     32'(mon_r.err));
                chk_eq("sb_len_err", 32'(out_len_err_m), 32'(mon_r.len_err));
                chk_eq("sb_words",   32'(out_words_m),   32'(mon_r.words));
                $display("result: inst=%0d crc=0x%04h err=%0d len_err=%0d words=%0d",
                         sel, out_crc_m, out_err_m, out_len_err_m, out_words_m);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nw;
        logic md;
        logic [13:0] ci;

        sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        mode = 1'b0; crc_in = 14'h0; out_ready = 1'b1;
        m_active = 1'b0; m_crc = 14'h0; m_cnt = 0; m_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("rst");

        // Single word 0x01, encode.
        send_word(8'h01, 1'b1, 1'b0, 14'h0, 1'b1);
        wait_valid(k);
        chk_eq("t040_latency", 32'(k),           32'd8);
        chk_eq("t040_crc",     32'(out_crc_m),   32'h0599);
        chk_eq("t040_err",     32'(out_err_m),   32'd0);
        chk_eq("t040_words",   32'(out_words_m), 32'd1);

        // Two words, in_ready gap after each acceptance.
        send_word(8'h00, 1'b0, 1'b0, 14'h0, 1'b1);
        check_ready_gap("t041_gap1");
        @(negedge clk);
        chk_eq("t041_wait_ready", 32'(in_ready_m), 32'd1);
        chk_eq("t041_wait_busy",  32'(busy_m),     32'd1);
        send_word(8'h01, 1'b1, 1'b0, 14'h0, 1'b1);
        check_ready_gap("t041_gap2");
        @(negedge clk);
        chk_eq("t041_crc",   32'(out_crc_m),   32'h0599);
        chk_eq("t041_words", 32'(out_words_m), 32'd2);

        // Check mode, good then bad CRC.
        send_word(8'h01, 1'b1, 1'b1, 14'h0599, 1'b1);
        wait_valid(k);
        chk_eq("t042_err_good", 32'(out_err_m), 32'd0);
        send_word(8'h01, 1'b1, 1'b1, 14'h0598, 1'b1);
        wait_valid(k);
        chk_eq("t042_err_bad", 32'(out_err_m), 32'd1);

        // mode only on first word, crc_in only on last word.
        send_word(8'hA5, 1'b0, 1'b0, 14'h1234, 1'b1);
        send_word(8'h3C, 1'b1, 1'b1, 14'h0000, 1'b1);
        wait_valid(k);
        chk_eq("t035_err", 32'(out_err_m), 32'd0);

        // Random frames through the scoreboard.
        for (int f = 0; f < 6; f++) begin
            nw = int'($urandom_range(1, 4));
            md = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++) begin
                ci = 14'($urandom);
                send_word(8'($urandom), (w == nw - 1), md, ci, 1'b1);
            end
        end

        // Back-pressure on the result.
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send_word(8'h01, 1'b1, 1'b0, 14'h0, 1'b1);
        wait_valid(k);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("t044_valid",    32'(out_valid_m), 32'd1);
            chk_eq("t044_in_ready", 32'(in_ready_m),  32'd0);
            chk_eq("t044_crc",      32'(out_crc_m),   32'h0599);
            chk_eq("t044_words",    32'(out_words_m), 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_eq("t044_idle_valid", 32'(out_valid_m), 32'd0);
        chk_eq("t044_idle_ready", 32'(in_ready_m),  32'd1);
        chk_eq("t044_idle_busy",  32'(busy_m),      32'd0);
        chk_eq("t044_hold_crc",   32'(out_crc_m),   32'h0599);

        // Reset on the 4th shift edge discards the frame.
        send_word(8'h01, 1'b1, 1'b0, 14'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_active = 1'b0;
        @(negedge clk);
        check_reset_values("t045_rst");
        send_word(8'h01, 1'b1, 1'b0, 14'h0, 1'b1);
        wait_valid(k);
        chk_eq("t045_crc", 32'(out_crc_m), 32'h0599);

        // Truncation on the MAX_WORDS=2 instance.
        repeat (4) @(negedge clk);
        sel = 1'b1;
        send_word(8'h00, 1'b0, 1'b0, 14'h0, 1'b1);
        send_word(8'h00, 1'b0, 1'b0, 14'h0, 1'b1);
        wait_valid(k);
        chk_eq("t043_words",   32'(out_words_m),   32'd2);
        chk_eq("t043_len_err", 32'(out_len_err_m), 32'd1);
        send_word(8'h00, 1'b0, 1'b0, 14'h0, 1'b1);
        send_word(8'h01, 1'b1, 1'b0, 14'h0, 1'b1);
        wait_valid(k);
        chk_eq("t043_new_words",   32'(out_words_m),   32'd2);
        chk_eq("t043_new_len_err", 32'(out_len_err_m), 32'd0);
        chk_eq("t043_new_crc",     32'(out_crc_m),     32'h0599);

        repeat (20) @(negedge clk);
        chk_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
